// File: rtl/muxn_scan_if.sv
`default_nettype none
// ============================================================================
// Module      : muxn_scan_if
// Description : Channel-data, select and status bundle for muxn_scan.
// Revision    : 1.0 - initial release
// ============================================================================
interface muxn_scan_if #(
    parameter int W = 1,
    parameter int N = 4,
    parameter int S = 2
);
    logic             mode;
    logic [S-1:0]     sel;
    logic [N*W-1:0]   din;
    logic [W-1:0]     dout;
    logic [S-1:0]     ch;
    logic             tick;
    logic             err;

    modport master (
        output mode, sel, din,
        input  dout, ch, tick, err
    );

    modport slave (
        input  mode, sel, din,
        output dout, ch, tick, err
    );
endinterface
`default_nettype wire

// File: rtl/muxn_scan.sv
`default_nettype none
// ============================================================================
// Module      : muxn_scan
// Description : Registered N-channel mux with manual select and timed scan.
// Revision    : 1.0 - initial release
// ============================================================================
module muxn_scan #(
    parameter int W     = 1,
    parameter int N     = 4,
    parameter int S     = 2,
    parameter int DWELL = 4
) (
    input  wire logic   clk,
    input  wire logic   reset_n,
    muxn_scan_if.slave  bus
);

    localparam logic [7:0]   C_DWELL_LAST = 8'(DWELL - 1);
    localparam logic [S-1:0] C_LAST_CH    = S'(N - 1);

    logic [S-1:0] ch_q,   ch_d;
    logic [7:0]   cnt_q,  cnt_d;
    logic [W-1:0] dout_q, dout_d;
    logic         tick_q, tick_d;
    logic         err_q,  err_d;
    logic         sel_valid;
    logic         dwell_done;

    always_comb begin
        sel_valid  = (int'(bus.sel) < N);
        dwell_done = (cnt_q == C_DWELL_LAST);
        ch_d       = ch_q;
        cnt_d      = 8'd0;
        dout_d     = '0;

        if (!bus.mode) begin
            // Manual mode discards any partially used dwell.
            if (sel_valid) begin
                ch_d = bus.sel;
            end
        end else if (dwell_done) begin
            ch_d = (ch_q == C_LAST_CH) ? '0 : ch_q + S'(1);
        end else begin
            cnt_d = cnt_q + 8'd1;
        end

        // Output tracks the channel being loaded, so dout and ch agree.
        for (int k = 0; k < N; k++) begin
            if (ch_d == S'(k)) begin
                dout_d = bus.din[k*W +: W];
            end
        end

        tick_d = (ch_d != ch_q);
        err_d  = !bus.mode && !sel_valid;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ch_q   <= '0;
            cnt_q  <= 8'd0;
            dout_q <= '0;
            tick_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            ch_q   <= ch_d;
            cnt_q  <= cnt_d;
            dout_q <= dout_d;
            tick_q <= tick_d;
            err_q  <= err_d;
        end
    end

    assign bus.ch   = ch_q;
    assign bus.dout = dout_q;
    assign bus.tick = tick_q;
    assign bus.err  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_muxn_scan.sv
`default_nettype none
// ============================================================================
// Module      : tb_muxn_scan
// Description : Directed self-checking bench for muxn_scan.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muxn_scan;

    logic clk     = 1'b0;
    logic rst_a_n = 1'b1;
    logic rst_b_n = 1'b0;
    logic rst_c_n = 1'b0;
    int   vectors     = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    // A: N=4, W=1, DWELL=3.  B: N=3, W=4, DWELL=2.  C: N=4, W=1, DWELL=4.
    muxn_scan_if #(.W(1), .N(4), .S(2)) if_a ();
    muxn_scan_if #(.W(4), .N(3), .S(2)) if_b ();
    muxn_scan_if #(.W(1), .N(4), .S(2)) if_c ();

    muxn_scan #(.W(1), .N(4), .S(2), .DWELL(3)) u_a (
        .clk(clk), .reset_n(rst_a_n), .bus(if_a));
    muxn_scan #(.W(4), .N(3), .S(2), .DWELL(2)) u_b (
        .clk(clk), .reset_n(rst_b_n), .bus(if_b));
    muxn_scan #(.W(1), .N(4), .S(2), .DWELL(4)) u_c (
        .clk(clk), .reset_n(rst_c_n), .bus(if_c));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        if_a.mode = 1'b0;
        if_a.sel  = 2'd0;
        if_a.din  = 4'b1111;
        #2 rst_a_n = 1'b0;
        #1;
        vectors++;
        if (if_a.dout !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_dout: got %b want 0", if_a.dout);
        end
        vectors++;
        if (if_a.ch !== 2'd0) begin
            miscompares++;
            $display("FAIL reset_ch: got %0d want 0", if_a.ch);
        end
        vectors++;
        if ({if_a.tick, if_a.err} !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_flags: got tick=%b err=%b want 0 0", if_a.tick, if_a.err);
        end
        #3 rst_a_n = 1'b1;
        step();
        vectors++;
        if ({if_a.dout, if_a.ch, if_a.tick} !== {1'b1, 2'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_release: got dout=%b ch=%0d tick=%b want 1 0 0",
                     if_a.dout, if_a.ch, if_a.tick);
        end
    endtask

    task automatic test_manual();
        if_a.mode = 1'b0;
        if_a.din  = 4'b0010;
        if_a.sel  = 2'd1;
        step();
        vectors++;
        if ({if_a.dout, if_a.ch, if_a.tick} !== {1'b1, 2'd1, 1'b1}) begin
            miscompares++;
            $display("FAIL manual_sel1: got dout=%b ch=%0d tick=%b want 1 1 1",
                     if_a.dout, if_a.ch, if_a.tick);
        end
        step();
        vectors++;
        if ({if_a.dout, if_a.ch, if_a.tick} !== {1'b1, 2'd1, 1'b0}) begin
            miscompares++;
            $display("FAIL manual_hold: got dout=%b ch=%0d tick=%b want 1 1 0",
                     if_a.dout, if_a.ch, if_a.tick);
        end
        if_a.sel = 2'd2;
        if_a.din = 4'b1101;
        step();
        vectors++;
        if ({if_a.dout, if_a.ch, if_a.tick} !== {1'b1, 2'd2, 1'b1}) begin
            miscompares++;
            $display("FAIL manual_sel2: got dout=%b ch=%0d tick=%b want 1 2 1",
                     if_a.dout, if_a.ch, if_a.tick);
        end
        // Data change while holding the channel shows up one edge later.
        if_a.din = 4'b1001;
        step();
        vectors++;
        if ({if_a.dout, if_a.ch, if_a.tick} !== {1'b0, 2'd2, 1'b0}) begin
            miscompares++;
            $display("FAIL manual_din: got dout=%b ch=%0d tick=%b want 0 2 0",
                     if_a.dout, if_a.ch, if_a.tick);
        end
    endtask

    task automatic test_scan_rotation();
        logic [3:0] din_rot = 4'b0101;
        int         exp_ch [12] = '{0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0};
        logic       exp_tick;
        logic       exp_dout;
        rst_a_n   = 1'b0;
        if_a.mode = 1'b1;
        if_a.din  = din_rot;
        #1 rst_a_n = 1'b1;
        for (int e = 0; e < 12; e++) begin
            step();
            exp_tick = (e % 3 == 2);
            exp_dout = din_rot[exp_ch[e]];
            vectors++;
            if ({if_a.ch, if_a.tick, if_a.dout} !== {2'(exp_ch[e]), exp_tick, exp_dout}) begin
                miscompares++;
                $display("FAIL scan_edge%0d: got ch=%0d tick=%b dout=%b want %0d %b %b",
                         e + 1, if_a.ch, if_a.tick, if_a.dout, exp_ch[e], exp_tick, exp_dout);
            end
        end
    endtask

    task automatic test_invalid_select();
        if_b.mode = 1'b0;
        if_b.din  = {4'hA, 4'h5, 4'h3};
        if_b.sel  = 2'd2;
        #1 rst_b_n = 1'b1;
        step();
        vectors++;
        if ({if_b.ch, if_b.err, if_b.dout} !== {2'd2, 1'b0, 4'hA}) begin
            miscompares++;
            $display("FAIL inv_sel2: got ch=%0d err=%b dout=%h want 2 0 a",
                     if_b.ch, if_b.err, if_b.dout);
        end
        if_b.sel = 2'd3;
        if_b.din = {4'hC, 4'h5, 4'h3};
        step();
        vectors++;
        if ({if_b.ch, if_b.err, if_b.tick, if_b.dout} !== {2'd2, 1'b1, 1'b0, 4'hC}) begin
            miscompares++;
            $display("FAIL inv_sel3: got ch=%0d err=%b tick=%b dout=%h want 2 1 0 c",
                     if_b.ch, if_b.err, if_b.tick, if_b.dout);
        end
        if_b.sel = 2'd0;
        step();
        vectors++;
        if ({if_b.ch, if_b.err, if_b.tick, if_b.dout} !== {2'd0, 1'b0, 1'b1, 4'h3}) begin
            miscompares++;
            $display("FAIL inv_sel0: got ch=%0d err=%b tick=%b dout=%h want 0 0 1 3",
                     if_b.ch, if_b.err, if_b.tick, if_b.dout);
        end
    endtask

    task automatic test_mode_switch();
        if_c.mode = 1'b1;
        if_c.sel  = 2'd0;
        if_c.din  = 4'b1010;
        #1 rst_c_n = 1'b1;
        repeat (6) step();
        vectors++;
        if (if_c.ch !== 2'd1) begin
            miscompares++;
            $display("FAIL switch_scan6: got ch=%0d want 1", if_c.ch);
        end
        if_c.mode = 1'b0;
        if_c.sel  = 2'd3;
        step();
        vectors++;
        if ({if_c.ch, if_c.tick, if_c.dout} !== {2'd3, 1'b1, 1'b1}) begin
            miscompares++;
            $display("FAIL switch_manual: got ch=%0d tick=%b dout=%b want 3 1 1",
                     if_c.ch, if_c.tick, if_c.dout);
        end
        if_c.mode = 1'b1;
        for (int e = 0; e < 3; e++) begin
            step();
            vectors++;
            if ({if_c.ch, if_c.tick} !== {2'd3, 1'b0}) begin
                miscompares++;
                $display("FAIL switch_dwell%0d: got ch=%0d tick=%b want 3 0",
                         e + 1, if_c.ch, if_c.tick);
            end
        end
        step();
        vectors++;
        if ({if_c.ch, if_c.tick, if_c.dout} !== {2'd0, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL switch_wrap: got ch=%0d tick=%b dout=%b want 0 1 0",
                     if_c.ch, if_c.tick, if_c.dout);
        end
        // Three more edges bring cnt to DWELL-1; manual must win on the next.
        repeat (3) step();
        if_c.mode = 1'b0;
        if_c.sel  = 2'd2;
        step();
        vectors++;
        if ({if_c.ch, if_c.tick, if_c.dout} !== {2'd2, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL switch_race: got ch=%0d tick=%b dout=%b want 2 1 0",
                     if_c.ch, if_c.tick, if_c.dout);
        end
    endtask

    task automatic test_reset_mid_scan();
        rst_a_n   = 1'b0;
        if_a.mode = 1'b1;
        if_a.din  = 4'b0101;
        #1 rst_a_n = 1'b1;
        repeat (6) step();
        vectors++;
        if ({if_a.ch, if_a.dout} !== {2'd2, 1'b1}) begin
            miscompares++;
            $display("FAIL midrst_pre: got ch=%0d dout=%b want 2 1", if_a.ch, if_a.dout);
        end
        #2 rst_a_n = 1'b0;
        #1;
        vectors++;
        if ({if_a.ch, if_a.dout, if_a.tick} !== {2'd0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL midrst_async: got ch=%0d dout=%b tick=%b want 0 0 0",
                     if_a.ch, if_a.dout, if_a.tick);
        end
        #1 rst_a_n = 1'b1;
        for (int e = 0; e < 2; e++) begin
            step();
            vectors++;
            if ({if_a.ch, if_a.tick, if_a.dout} !== {2'd0, 1'b0, 1'b1}) begin
                miscompares++;
                $display("FAIL midrst_hold%0d: got ch=%0d tick=%b dout=%b want 0 0 1",
                         e + 1, if_a.ch, if_a.tick, if_a.dout);
            end
        end
        step();
        vectors++;
        if ({if_a.ch, if_a.tick, if_a.dout} !== {2'd1, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL midrst_advance: got ch=%0d tick=%b dout=%b want 1 1 0",
                     if_a.ch, if_a.tick, if_a.dout);
        end
    endtask

    initial begin
        if_b.mode = 1'b0;
        if_b.sel  = 2'd0;
        if_b.din  = '0;
        if_c.mode = 1'b0;
        if_c.sel  = 2'd0;
        if_c.din  = '0;
        test_reset();
        test_manual();
        test_scan_rotation();
        test_invalid_select();
        test_mode_switch();
        test_reset_mid_scan();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/muxn_scan.md
# muxn_scan

Parametrised, registered N-channel multiplexer of W-bit inputs with a manual select mode and an automatic scan mode. In scan mode it steps through all channels on a programmable dwell period. It succeeds the combinational 4:1 mux in the datapath exercises. Output, channel index and status flags are all registered, so the block can feed synchronous logic directly.

## Interface
- W, default 1: data width per channel.
- N, default 4: number of channels, 2..16, need not be a power of two.
- S, default 2: select/index width; must satisfy 2^S >= N.
- DWELL, default 4: cycles spent on each channel in scan mode, 1..255.
- clk, input, 1: the only clock; all state updates on the rising edge.
- reset_n, input, 1: asynchronous, active-low reset.
- mode, input, 1: 0 = manual select, 1 = automatic scan.
- sel, input, S: channel request in manual mode; ignored in scan mode.
- din, input, N*W: flattened channel data; channel k occupies bits [k*W+W-1 : k*W].
- dout, output, W: registered selected data.
- ch, output, S: registered index of the channel currently driving dout.
- tick, output, 1: one-cycle pulse, high in the cycle ch first shows a new value.
- err, output, 1: registered; high while a manual request with sel >= N was seen at the last edge.

## Operation
- State: ch register (S bits), dwell counter cnt (8 bits), dout, tick, err.
- Next-channel rule, ch_next:
  - Manual, sel < N: ch_next = sel.
  - Manual, sel >= N: ch_next = ch (hold).
  - Scan, cnt == DWELL-1: ch_next = (ch == N-1) ? 0 : ch+1.
  - Scan, otherwise: ch_next = ch.
- Each edge:
  - ch <= ch_next.
  - dout <= din[ch_next] (the new channel's data, not the old), so dout and ch always agree.
  - tick <= (ch_next != ch).
  - err <= (mode == 0 && sel >= N).
- Dwell counter:
  - Manual mode: cnt held at 0.
  - Scan mode: cnt increments each edge and wraps to 0 on the edge where it equals DWELL-1; that same edge advances ch.
  - DWELL = 1: advance ch every cycle, tick permanently high.
- Mode switches:
  - Manual→scan: cnt is 0 and scanning starts from the current ch. The first advance occurs on the DWELL-th edge with mode = 1.
  - Scan→manual: on the first edge with mode = 0, ch jumps to sel (if valid) and cnt clears to 0. A partially used dwell is discarded.
- Data changes on din during a dwell appear on dout one edge later; the channel is not re-selected.

## Timing
- Reset (reset_n low, asynchronous, no clock needed): ch = 0, cnt = 0, dout = 0, tick = 0, err = 0.
- Release: the first active edge after reset_n rises evaluates normally.
- Reset asserted mid-scan: all state clears immediately. After release, scanning restarts at channel 0 with a full dwell.
- Latency, manual mode: sel or din change to dout/ch is exactly 1 cycle; no combinational path from inputs to outputs.
- Scan period: each channel is held exactly DWELL cycles. A full rotation takes N*DWELL cycles.
- Wrap-around: ch goes N-1 → 0, with tick pulsing as on any other advance.
- Simultaneous events:
  - mode falling on the same edge cnt would reach DWELL-1: manual wins, ch = sel.
  - Manual sel equal to the current ch: tick stays 0.

## Test plan
- Reset, N=4, W=1:
  - Drive reset_n=0 with din=4'b1111.
  - Required: dout=0, ch=0, tick=0, err=0 without any clock edge.
  - After release with mode=0, sel=0: dout=1 after one edge.
- Manual select, W=1:
  - din={d,c,b,a}={0,0,1,0}, sel=1.
  - Required: next edge gives dout=1, ch=1, tick=1; the following edge gives tick=0.
  - Then sel=2, din=4'b1101: one edge later dout=1, ch=2.
- Scan rotation, N=4, DWELL=3, mode=1 from reset:
  - Required: ch sequence 0,0,0,1,1,1,2,2,2,3,3,3,0 on successive edges.
  - tick high exactly on edges 3, 6, 9 and 12; dout tracks din[ch].
- Invalid select, instance N=3, S=2, mode=0:
  - Required: sel=2 gives ch=2. Then sel=3 gives ch stays 2, err=1, dout=din[2].
  - Then sel=0 gives ch=0, err=0.
- Mode switch, N=4, DWELL=4:
  - Scan for 6 edges (ch=1, cnt=2), then mode=0, sel=3.
  - Required: next edge gives ch=3, tick=1.
  - Then mode=1: ch stays 3 for 4 edges, then goes to 0 with tick=1.
- Reset mid-scan:
  - Assert reset_n=0 while ch=2 for 2 ns between edges.
  - Required: ch=0 and dout=0 immediately; after release ch stays 0 for DWELL edges.
